// File: rtl/ir_fetch_unit.sv
// rtl/ir_fetch_unit.sv - instruction fetch unit: PC/IR registers and an IDLE/REQ/ERR memory read FSM
module ir_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 9,
  parameter int          TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [31:0]       pc_in,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data_in,
  output logic [31:0]       IR,
  output logic [31:0]       PC,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        // A simultaneous pc_load steers the fetch that starts this cycle.
        if (pc_load) pc_d = pc_in;
        if (fetch_start) begin
          state_d = S_REQ;
          valid_d = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
        end
      end
      S_REQ: begin
        // Data arriving on the final allowed cycle is accepted ahead of the timeout.
        if (mem_ready) begin
          ir_d    = mem_data_in;
          pc_d    = pc_q + 32'd1;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_read  = (state_q == S_REQ);
  assign busy      = (state_q == S_REQ);
  assign mem_addr  = pc_q[ADDR_W-1:0];
  assign IR        = ir_q;
  assign PC        = pc_q;
  assign ir_valid  = valid_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb/tb_ir_fetch_unit.sv - directed self-checking bench for ir_fetch_unit
module tb_ir_fetch_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        mem_read;
  logic [8:0]  mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data_in = 32'd0;
  logic [31:0] IR;
  logic [31:0] PC;
  logic        ir_valid;
  logic        busy;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  ir_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(9), .TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_in(pc_in), .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_data_in(mem_data_in), .IR(IR), .PC(PC), .ir_valid(ir_valid),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset
    #1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_val("rst_pc", PC, 32'h0);
    check_val("rst_ir", IR, 32'h0);
    check_val("rst_valid", {31'd0, ir_valid}, 32'd0);
    check_val("rst_err", {31'd0, fetch_err}, 32'd0);
    check_val("rst_rd", {31'd0, mem_read}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);

    // Zero-wait fetch; ready already high in IDLE must not load IR
    mem_ready   = 1'b1;
    mem_data_in = 32'h0880_0005;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_val("zw_rd", {31'd0, mem_read}, 32'd1);
    check_val("zw_busy", {31'd0, busy}, 32'd1);
    check_val("zw_addr", {23'd0, mem_addr}, 32'd0);
    check_val("zw_ir_hold", IR, 32'h0);
    step();
    check_val("zw_ir", IR, 32'h0880_0005);
    check_val("zw_pc", PC, 32'd1);
    check_val("zw_valid", {31'd0, ir_valid}, 32'd1);
    check_val("zw_rd_off", {31'd0, mem_read}, 32'd0);

    // Three wait cycles: read held for four cycles
    mem_ready   = 1'b0;
    mem_data_in = 32'hDEAD_BEEF;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("w3_rd%0d", i), {31'd0, mem_read}, 32'd1);
      check_val($sformatf("w3_busy%0d", i), {31'd0, busy}, 32'd1);
      check_val($sformatf("w3_valid%0d", i), {31'd0, ir_valid}, 32'd0);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    check_val("w3_ir", IR, 32'hDEAD_BEEF);
    check_val("w3_pc", PC, 32'd2);
    check_val("w3_err", {31'd0, fetch_err}, 32'd0);
    check_val("w3_rd_off", {31'd0, mem_read}, 32'd0);

    // Never ready: timeout after 15 REQ cycles
    mem_data_in = 32'h1234_5678;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check_val($sformatf("to_rd%0d", i), {31'd0, mem_read}, 32'd1);
      check_val($sformatf("to_err%0d", i), {31'd0, fetch_err}, 32'd0);
      step();
    end
    check_val("to_err", {31'd0, fetch_err}, 32'd1);
    check_val("to_rd_off", {31'd0, mem_read}, 32'd0);
    check_val("to_busy_off", {31'd0, busy}, 32'd0);
    check_val("to_ir", IR, 32'hDEAD_BEEF);
    check_val("to_pc", PC, 32'd2);
    // ready in ERR ignored
    mem_ready = 1'b1;
    step();
    check_val("err_ir_hold", IR, 32'hDEAD_BEEF);
    check_val("err_pc_hold", PC, 32'd2);
    check_val("err_hold", {31'd0, fetch_err}, 32'd1);
    // retry at same PC
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_val("retry_err_clr", {31'd0, fetch_err}, 32'd0);
    check_val("retry_addr", {23'd0, mem_addr}, 32'd2);
    check_val("retry_rd", {31'd0, mem_read}, 32'd1);
    step();
    mem_ready = 1'b0;
    check_val("retry_ir", IR, 32'h1234_5678);
    check_val("retry_pc", PC, 32'd3);
    check_val("retry_valid", {31'd0, ir_valid}, 32'd1);

    // Ready on the cycle the counter would hit TIMEOUT wins
    mem_data_in = 32'hCAFE_0001;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check_val("edge_rd", {31'd0, mem_read}, 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_val("edge_ir", IR, 32'hCAFE_0001);
    check_val("edge_pc", PC, 32'd4);
    check_val("edge_err", {31'd0, fetch_err}, 32'd0);
    check_val("edge_valid", {31'd0, ir_valid}, 32'd1);

    // pc_load with fetch_start in IDLE; pc_load/fetch_start in REQ ignored
    mem_data_in = 32'hA5A5_0F0F;
    pc_load     = 1'b1;
    pc_in       = 32'h0000_01F0;
    fetch_start = 1'b1;
    step();
    pc_in = 32'h0000_0055;
    check_val("ld_addr", {23'd0, mem_addr}, 32'h1F0);
    check_val("ld_pc", PC, 32'h1F0);
    step();
    pc_load     = 1'b0;
    fetch_start = 1'b0;
    check_val("ld_req_pc", PC, 32'h1F0);
    check_val("ld_req_rd", {31'd0, mem_read}, 32'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_val("ld_pc_after", PC, 32'h1F1);
    check_val("ld_ir", IR, 32'hA5A5_0F0F);

    // PC wrap
    pc_load = 1'b1;
    pc_in   = 32'hFFFF_FFFF;
    step();
    pc_load = 1'b0;
    check_val("wr_pc_ld", PC, 32'hFFFF_FFFF);
    check_val("wr_addr_ld", {23'd0, mem_addr}, 32'h1FF);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    mem_ready   = 1'b1;
    step();
    mem_ready = 1'b0;
    check_val("wr_pc", PC, 32'h0);
    check_val("wr_addr", {23'd0, mem_addr}, 32'h0);

    // clear in second REQ cycle with ready high
    mem_data_in = 32'h7777_7777;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    clear     = 1'b1;
    mem_ready = 1'b1;
    step();
    clear     = 1'b0;
    mem_ready = 1'b0;
    check_val("clr_ir", IR, 32'h0);
    check_val("clr_pc", PC, 32'h0);
    check_val("clr_valid", {31'd0, ir_valid}, 32'd0);
    check_val("clr_rd", {31'd0, mem_read}, 32'd0);
    check_val("clr_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_fetch_unit.md
IR_FETCH_UNIT -- requirements
Module: ir_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: ADDR_W, default 9, width of the memory word address (512-word memory).
REQ-003 Parameter: TIMEOUT, default 15, maximum REQ-state cycles without mem_ready before an error; legal range 1..255.
REQ-004 Port: clock  input  1  single clock, all state changes on its rising edge.
REQ-005 Port: clear  input  1  reset, synchronous and active-high.
REQ-006 Port: fetch_start  input  1  one-cycle request from the control sequencer to fetch the next instruction.
REQ-007 Port: pc_load  input  1  load PC from pc_in (branch/jump).
REQ-008 Port: pc_in  input  32  new PC value from the bus.
REQ-009 Port: mem_read  output  1  memory read strobe.
REQ-010 Port: mem_addr  output  ADDR_W  word address, always equal to PC[ADDR_W-1:0].
REQ-011 Port: mem_ready  input  1  memory data valid this cycle.
REQ-012 Port: mem_data_in  input  32  memory read data.
REQ-013 Port: IR  output  32  instruction register, feeding the register select/encode stage and the constant sign-extend path.
REQ-014 Port: PC  output  32  program counter.
REQ-015 Port: ir_valid  output  1  IR holds a freshly fetched instruction.
REQ-016 Port: busy  output  1  fetch in progress (state REQ).
REQ-017 Port: fetch_err  output  1  last fetch timed out.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ, and ERR; all outputs are registered or decoded from state only.
REQ-019 IDLE: on fetch_start go to REQ, clear ir_valid and fetch_err, and zero the wait counter.
REQ-020 REQ: mem_read=1 and busy=1; all other states drive mem_read=0 and busy=0.
REQ-021 REQ with mem_ready=1: IR <= mem_data_in, PC <= PC+1, ir_valid <= 1, return to IDLE.
REQ-022 Latency: fetch_start at edge N gives mem_read high in cycle N+1; zero-wait memory gives IR/ir_valid updated at edge N+2.
REQ-023 REQ with mem_ready=0: the wait counter increments; when the counter reaches TIMEOUT, go to ERR with fetch_err <= 1, leaving IR and PC unchanged.
REQ-024 mem_ready in the same cycle the counter would reach TIMEOUT SHALL win: data is accepted and no error is raised.
REQ-025 ERR: hold fetch_err=1; fetch_start retries at the same PC (go to REQ, clear fetch_err).
REQ-026 pc_load in IDLE or ERR: PC <= pc_in.
REQ-027 pc_load together with fetch_start in IDLE or ERR: the PC load and the state change both happen, and the fetch uses pc_in.
REQ-028 pc_load and fetch_start in REQ SHALL be ignored.
REQ-029 mem_ready outside REQ SHALL be ignored, with no change to IR or PC.
REQ-030 The PC increment SHALL be modulo 2^32: 32'hFFFF_FFFF+1 gives 0; mem_addr wraps accordingly.
REQ-031 The IR SHALL change only per REQ-021 or reset.

Reset
REQ-032 clear=1 at an edge SHALL force state IDLE, PC=RESET_PC, IR=0, ir_valid=0, fetch_err=0, counter=0, mem_read=0, and busy=0, regardless of state.
REQ-033 clear SHALL take priority over every other input.
REQ-034 clear asserted mid-fetch (REQ) SHALL abort the fetch; a mem_ready in the same cycle is discarded.

Verification
REQ-035 Reset then fetch_start with a zero-wait memory holding 32'h0880_0005 at word 0: mem_read high 1 cycle, mem_addr=0, then IR=32'h0880_0005, PC=1, ir_valid=1.
REQ-036 Memory with 3 wait cycles: mem_read held high 4 cycles, busy high throughout, no fetch_err, IR loaded, PC incremented by 1.
REQ-037 Memory never ready with TIMEOUT=15: fetch_err=1 after 15 REQ cycles with IR and PC unchanged; then fetch_start plus a ready memory clears fetch_err and loads IR.
REQ-038 pc_load=1, pc_in=32'h0000_01F0, and fetch_start in the same IDLE cycle: mem_addr=9'h1F0 during REQ, PC=32'h1F1 after the fetch; pc_load pulsed during REQ has no effect.
REQ-039 PC=32'hFFFF_FFFF, fetch completes: PC=0 and mem_addr=0.
REQ-040 clear asserted in the second REQ cycle with mem_ready=1: IR=0, PC=RESET_PC, ir_valid=0, and mem_read=0 on the next cycle.
